// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } pip_reg_fet_dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - synchronous FIFO with flush, used for fetched words and pc tags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_COUNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: owns the PC, issues in-order imem requests, buffers
// returned instructions and drives the fet_dec pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output pip_reg_fet_dec_t o_fet_dec,
  output logic             fet_dec_write_en
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] CREDIT = SW'(FIFO_DEPTH);
  localparam logic [31:0]   PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_pop;
  logic [SW-1:0] in_flight;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] tag_count;
  logic [31:0]   tag_head;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_push_entry;

  // Buffered words plus pending requests may never exceed the buffer, so responses always fit
  assign in_flight      = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && (in_flight < CREDIT);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

  always_comb begin
    fifo_push_entry.pc    = tag_head;
    fifo_push_entry.instr = imem_rsp_data;
  end

  always_comb begin
    o_fet_dec        = '0;
    fet_dec_write_en = 1'b1;
    fifo_pop         = 1'b0;
    if (redirect_valid) begin
      fet_dec_write_en = 1'b1;
    end else if (stall) begin
      fet_dec_write_en = 1'b0;
    end else if (fifo_count != '0) begin
      o_fet_dec.valid = 1'b1;
      o_fet_dec.pc    = fifo_head.pc;
      o_fet_dec.instr = fifo_head.instr;
      fifo_pop        = 1'b1;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc & PC_MASK;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC & PC_MASK;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FETCH_ENTRY_W)) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (fifo_push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Tags of dropped requests are flushed on redirect, so only kept responses consume one
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head_data (tag_head),
    .count     (tag_count)
  );

  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_q != '0));

  kept_rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (tag_count != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a queued imem model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic             clk;
  logic             rst;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  pip_reg_fet_dec_t o_fet_dec;
  logic             fet_dec_write_en;

  logic             w_req_valid;
  logic [31:0]      w_req_addr;
  pip_reg_fet_dec_t w_fet_dec;
  logic             w_write_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  logic             s_req_valid;
  logic [31:0]      s_addr;
  logic             s_we;
  pip_reg_fet_dec_t s_out;

  logic [31:0] req_log[$];
  logic [31:0] out_pc[$];
  logic [31:0] out_instr[$];
  int          out_cyc[$];
  logic [31:0] w_log[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .o_fet_dec(o_fet_dec), .fet_dec_write_en(fet_dec_write_en)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .o_fet_dec(w_fet_dec), .fet_dec_write_en(w_write_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample the cycle, then advance one edge and let the imem model answer in request order
  task automatic tick();
    logic hs;
    logic rsp_taken;
    #1;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_we        = fet_dec_write_en;
    s_out       = o_fet_dec;
    hs          = imem_req_valid && imem_req_ready;
    rsp_taken   = imem_rsp_valid;
    if (hs) req_log.push_back(imem_req_addr);
    if (fet_dec_write_en && o_fet_dec.valid) begin
      out_pc.push_back(o_fet_dec.pc);
      out_instr.push_back(o_fet_dec.instr);
      out_cyc.push_back(cyc);
    end
    if (w_req_valid) w_log.push_back(w_req_addr);
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_taken && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (hs) begin
      pend_addr.push_back(s_addr);
      pend_due.push_back(cyc + lat - 1);
    end
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pend_addr[0];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_log.delete(); out_pc.delete(); out_instr.delete(); out_cyc.delete();
    w_log.delete(); pend_addr.delete(); pend_due.delete();
    cyc = 0;
    lat = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    #2;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++; if (o_fet_dec !== '0) begin n_fail++; $display("FAIL reset_fet_dec: got %h expected 0", o_fet_dec); end
    n_checks++; if (fet_dec_write_en !== 1'b1) begin n_fail++; $display("FAIL reset_write_en: got %b expected 1", fet_dec_write_en); end
    n_checks++; if (w_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_req_valid: got %b expected 0", w_req_valid); end
    do_reset();
    tick();
    n_checks++; if (s_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b expected 1", s_req_valid); end
    n_checks++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL first_req_addr: got %h expected 00000000", s_addr); end
    n_checks++; if (s_out.valid !== 1'b0 || s_we !== 1'b1) begin n_fail++; $display("FAIL first_bubble: got valid %b we %b expected valid 0 we 1", s_out.valid, s_we); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    repeat (14) tick();
    n_checks++;
    if (req_log.size() < 6) begin n_fail++; $display("FAIL stream_req_count: got %0d expected >=6", req_log.size()); end
    else for (int i = 0; i < 6; i++) begin
      exp = 32'(4 * i);
      n_checks++; if (req_log[i] !== exp) begin n_fail++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, req_log[i], exp); end
    end
    n_checks++;
    if (out_pc.size() < 5) begin n_fail++; $display("FAIL stream_out_count: got %0d expected >=5", out_pc.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        exp = 32'(4 * i);
        n_checks++; if (out_pc[i] !== exp) begin n_fail++; $display("FAIL stream_out_pc[%0d]: got %h expected %h", i, out_pc[i], exp); end
        n_checks++; if (out_instr[i] !== ~exp) begin n_fail++; $display("FAIL stream_out_instr[%0d]: got %h expected %h", i, out_instr[i], ~exp); end
      end
      n_checks++; if (out_cyc[0] !== 2) begin n_fail++; $display("FAIL stream_first_out_cycle: got %0d expected 2", out_cyc[0]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    do_reset();
    stall = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (s_we !== 1'b0) begin n_fail++; $display("FAIL stall_write_en[%0d]: got %b expected 0", i, s_we); end
      n_checks++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_credit[%0d]: got %b expected 0", i, s_req_valid); end
    end
    n_checks++; if (out_pc.size() != 0) begin n_fail++; $display("FAIL stall_no_output: got %0d outputs expected 0", out_pc.size()); end
    stall = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (out_pc.size() < 4) begin n_fail++; $display("FAIL stall_resume_count: got %0d expected >=4", out_pc.size()); end
    else for (int i = 0; i < 4; i++) begin
      exp = 32'(4 * i);
      n_checks++; if (out_pc[i] !== exp || out_instr[i] !== ~exp) begin n_fail++; $display("FAIL stall_resume[%0d]: got pc %h instr %h expected pc %h instr %h", i, out_pc[i], out_instr[i], exp, ~exp); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    tick();
    tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    n_checks++; if (s_we !== 1'b1) begin n_fail++; $display("FAIL redirect_over_stall_we: got %b expected 1", s_we); end
    n_checks++; if (s_out.valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush_valid: got %b expected 0", s_out.valid); end
    n_checks++; if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_no_req: got %b expected 0", s_req_valid); end
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (10) tick();
    n_checks++;
    if (req_log.size() < 3) begin n_fail++; $display("FAIL redirect_req_count: got %0d expected >=3", req_log.size()); end
    else begin
      n_checks++; if (req_log[2] !== 32'h100) begin n_fail++; $display("FAIL redirect_req_addr: got %h expected 00000100", req_log[2]); end
    end
    n_checks++;
    if (out_pc.size() < 1) begin n_fail++; $display("FAIL redirect_out_count: got 0 expected >=1"); end
    else begin
      n_checks++; if (out_pc[0] !== 32'h100) begin n_fail++; $display("FAIL redirect_first_pc: got %h expected 00000100", out_pc[0]); end
      n_checks++; if (out_instr[0] !== 32'hFFFF_FEFF) begin n_fail++; $display("FAIL redirect_first_instr: got %h expected fffffeff", out_instr[0]); end
    end
  endtask

  task automatic test_ready_hold();
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (s_req_valid !== 1'b1 || s_addr !== 32'h0) begin n_fail++; $display("FAIL ready_hold[%0d]: got valid %b addr %h expected valid 1 addr 00000000", i, s_req_valid, s_addr); end
    end
    imem_req_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (s_addr !== 32'h4) begin n_fail++; $display("FAIL ready_release_addr: got %h expected 00000004", s_addr); end
    n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL ready_release_count: got %0d expected 2", req_log.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_pc = 32'h0000_0302;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (10) tick();
    n_checks++;
    if (req_log.size() < 3) begin n_fail++; $display("FAIL b2b_req_count: got %0d expected >=3", req_log.size()); end
    else begin
      n_checks++; if (req_log[2] !== 32'h300) begin n_fail++; $display("FAIL b2b_req_addr: got %h expected 00000300", req_log[2]); end
    end
    n_checks++;
    if (out_pc.size() < 1) begin n_fail++; $display("FAIL b2b_out_count: got 0 expected >=1"); end
    else begin
      n_checks++; if (out_pc[0] !== 32'h300) begin n_fail++; $display("FAIL b2b_first_pc: got %h expected 00000300", out_pc[0]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (6) tick();
    n_checks++;
    if (w_log.size() != 4) begin n_fail++; $display("FAIL wrap_req_count: got %0d expected 4", w_log.size()); end
    else begin
      n_checks++; if (w_log[0] !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr0: got %h expected fffffff8", w_log[0]); end
      n_checks++; if (w_log[1] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr1: got %h expected fffffffc", w_log[1]); end
      n_checks++; if (w_log[2] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr2: got %h expected 00000000", w_log[2]); end
      n_checks++; if (w_log[3] !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_addr3: got %h expected 00000004", w_log[3]); end
    end
    n_checks++; if (w_req_valid !== 1'b0 || w_write_en !== 1'b1 || w_fet_dec.valid !== 1'b0) begin n_fail++; $display("FAIL wrap_credit_exhausted: got req %b we %b valid %b expected 0 1 0", w_req_valid, w_write_en, w_fet_dec.valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_hold();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
